// File: rtl/conv3x3_window_mac.sv
// Streaming 3x3 convolution: sliding window, edge-aware valid tracking, 3-stage MAC tree.
// Define CONV_RELU_EN to clamp negative results to zero in the final stage.
module conv3x3_window_mac #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  localparam int ACC_W = 2*WIDTH+5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclr,
  input  logic                    tap_valid,
  input  logic [WIDTH-1:0]        row0,
  input  logic [WIDTH-1:0]        row1,
  input  logic [WIDTH-1:0]        row2,
  input  logic                    w_load,
  input  logic [9*WIDTH-1:0]      w_in,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last
);
  localparam int PW = 2*WIDTH+1;
  localparam int SW = 2*WIDTH+3;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);

  logic [WIDTH-1:0]        win [3][3];
  logic [9*WIDTH-1:0]      kernel;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    accept;
  logic                    win_ok;
  logic                    win_end;
  logic                    v0, l0, v1, l1, v2, l2;
  logic signed [PW-1:0]    prod [9];
  logic signed [SW-1:0]    rsum [3];
  logic signed [ACC_W-1:0] total;
  logic signed [ACC_W-1:0] result;

  // Counters describe the tap being accepted, so window validity is decided combinationally.
  assign accept  = tap_valid && !sclr;
  assign win_ok  = (col >= CW'(2)) && (row >= RW'(2));
  assign win_end = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (sclr) begin
      col <= '0;
      row <= '0;
    end else if (tap_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row0;
      win[1][2] <= row1;
      win[2][2] <= row2;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kernel <= '0;
    else if (w_load)
      kernel <= w_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v0, l0, v1, l1, v2, l2} <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (sclr) begin
      {v0, l0, v1, l1, v2, l2} <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      v0        <= accept && win_ok;
      l0        <= accept && win_ok && win_end;
      v1        <= v0;
      l1        <= l0;
      v2        <= v1;
      l2        <= l1;
      out_valid <= v2;
      out_last  <= l2;
    end
  end

  always_comb begin
    total = ACC_W'(rsum[0]) + ACC_W'(rsum[1]) + ACC_W'(rsum[2]);
  end

`ifdef CONV_RELU_EN
  assign result = total[ACC_W-1] ? '0 : total;
`else
  assign result = total;
`endif

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) prod[k] <= '0;
      for (int r = 0; r < 3; r++) rsum[r] <= '0;
      out_data <= '0;
    end else begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod[3*r+c] <= PW'($signed({1'b0, win[r][c]})) *
                         PW'($signed(kernel[(3*r+c)*WIDTH +: WIDTH]));
      for (int r = 0; r < 3; r++)
        rsum[r] <= SW'(prod[3*r]) + SW'(prod[3*r+1]) + SW'(prod[3*r+2]);
      if (v2)
        out_data <= result;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Directed testbench for conv3x3_window_mac on a 4x4 image with hand-computed results.
// Honours CONV_RELU_EN when predicting negative sums.
module tb_conv3x3_window_mac;
  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int ACC_W = 2*WIDTH+5;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // Kernels packed w8..w0; A probes column order and all three rows, B is newest-top only.
  localparam logic [9*WIDTH-1:0] K_ONES   = {9{8'h01}};
  localparam logic [9*WIDTH-1:0] K_CENTRE = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [9*WIDTH-1:0] K_MIN    = {9{8'h80}};
  localparam logic [9*WIDTH-1:0] K_MAX    = {9{8'h7F}};
  localparam logic [9*WIDTH-1:0] K_A      = {8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h04, 8'h02, 8'h01};
  localparam logic [9*WIDTH-1:0] K_B      = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclr = 1'b0;
  logic tap_valid = 1'b0;
  logic w_load = 1'b0;
  logic [WIDTH-1:0] row0 = '0;
  logic [WIDTH-1:0] row1 = '0;
  logic [WIDTH-1:0] row2 = '0;
  logic [9*WIDTH-1:0] w_in = '0;
  logic signed [ACC_W-1:0] out_data;
  logic out_valid;
  logic out_last;

  int edge_no = 0;
  int n_vec = 0;
  int n_err = 0;
  logic signed [31:0] got_data [$];
  int                 got_edge [$];
  logic               got_last [$];

  conv3x3_window_mac #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .tap_valid(tap_valid),
    .row0(row0), .row1(row1), .row2(row2),
    .w_load(w_load), .w_in(w_in),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int relu_exp(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  // One clock: inputs were set before the edge, outputs are logged at the following negedge.
  task automatic tick();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    if (out_valid) begin
      got_data.push_back(out_data);
      got_edge.push_back(edge_no);
      got_last.push_back(out_last);
    end
  endtask

  task automatic load_kernel(input logic [9*WIDTH-1:0] k);
    w_in   = k;
    w_load = 1'b1;
    tick();
    w_load = 1'b0;
  endtask

  task automatic start_frame();
    edge_no = 0;
    got_data.delete();
    got_edge.delete();
    got_last.delete();
  endtask

  task automatic feed_frame(input bit varied, input logic [7:0] pv, input int gap,
                            input int n_taps, input int wl_at);
    for (int t = 0; t < n_taps; t++) begin
      tap_valid = 1'b1;
      row0      = varied ? 8'(t) : pv;
      row1      = varied ? 8'd50 : pv;
      row2      = varied ? 8'(t) : pv;
      w_load    = (t == wl_at);
      tick();
      tap_valid = 1'b0;
      w_load    = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    repeat (6) tick();
  endtask

  // Valid windows of a 4x4 frame complete at taps 10, 11, 14 and 15.
  task automatic check_frame(input string tag, input int gap,
                             input int e0, input int e1, input int e2, input int e3);
    int taps [4];
    int exp_v [4];
    taps  = '{10, 11, 14, 15};
    exp_v = '{e0, e1, e2, e3};
    check($sformatf("%s count", tag), got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s data%0d", tag, i), got_data[i], exp_v[i]);
        check($sformatf("%s edge%0d", tag, i), got_edge[i], taps[i]*(gap+1) + 1 + 3);
        check($sformatf("%s last%0d", tag, i), got_last[i], (i == 3));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    repeat (2) tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset out_data", out_data, 0);
    rst = 1'b0;

    load_kernel(K_ONES);
    start_frame();
    feed_frame(1'b0, 8'd1, 0, 16, -1);
    check_frame("ones", 0, 9, 9, 9, 9);

    load_kernel(K_CENTRE);
    start_frame();
    feed_frame(1'b0, 8'd200, 0, 16, -1);
    check_frame("centre", 0, relu_exp(-200), relu_exp(-200), relu_exp(-200), relu_exp(-200));

    load_kernel(K_MIN);
    start_frame();
    feed_frame(1'b0, 8'd255, 0, 16, -1);
    check_frame("min", 0, relu_exp(-293760), relu_exp(-293760), relu_exp(-293760), relu_exp(-293760));

    load_kernel(K_MAX);
    start_frame();
    feed_frame(1'b0, 8'd255, 0, 16, -1);
    check_frame("max", 0, 291465, 291465, 291465, 291465);

    load_kernel(K_A);
    start_frame();
    feed_frame(1'b1, 8'd0, 0, 16, -1);
    check_frame("varied", 0, 108, 114, 132, 138);

    start_frame();
    feed_frame(1'b1, 8'd0, 1, 16, -1);
    check_frame("toggle", 1, 108, 114, 132, 138);

    // Partial frame interrupted by reset; the next frame must start at row 0, col 0.
    start_frame();
    for (int t = 0; t < 7; t++) begin
      tap_valid = 1'b1;
      row0 = 8'(t);
      row1 = 8'd50;
      row2 = 8'(t);
      tick();
    end
    tap_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst kernel", (dut.kernel != '0), 0);
    tick();
    rst = 1'b0;
    check("midrst partial count", got_data.size(), 0);
    load_kernel(K_A);
    start_frame();
    feed_frame(1'b1, 8'd0, 0, 16, -1);
    check_frame("after_rst", 0, 108, 114, 132, 138);

    // sclr with a tap: tap dropped, counters zeroed, in-flight windows discarded.
    start_frame();
    for (int t = 0; t < 12; t++) begin
      tap_valid = 1'b1;
      row0 = 8'(t);
      row1 = 8'd50;
      row2 = 8'(t);
      tick();
    end
    sclr = 1'b1;
    row0 = 8'd99;
    tick();
    sclr = 1'b0;
    tap_valid = 1'b0;
    check("sclr col", dut.col, 0);
    check("sclr row", dut.row, 0);
    repeat (4) tick();
    check("sclr flushed count", got_data.size(), 0);
    start_frame();
    feed_frame(1'b1, 8'd0, 0, 16, -1);
    check_frame("after_sclr", 0, 108, 114, 132, 138);

    // Kernel swap on the edge that multiplies the first window.
    w_in = K_B;
    start_frame();
    feed_frame(1'b1, 8'd0, 0, 16, 11);
    check_frame("wload", 0, 108, 11, 14, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_mac.md
# conv3x3_window_mac

Streaming 3x3 convolution stage that sits directly downstream of the line-buffer shift-register chain. Each cycle the chain presents one vertically aligned column of three pixels. The block assembles a 3x3 sliding window, tracks image position so that windows straddling row edges are suppressed, and multiplies the window by a loadable signed kernel. A pipelined adder tree then emits one convolution result per valid window, with no backpressure.

## Interface
Parameters:
- WIDTH, 8: pixel and weight bit width.
- IMG_W, 28: image width in pixels (≥3).
- IMG_H, 28: image height in pixels (≥3).
- ACC_W (localparam), 2*WIDTH+5: result width.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- sclr  in  1: synchronous soft clear of position counters and valid pipeline.
- tap_valid  in  1: a new pixel column is present on row taps.
- row0  in  WIDTH: unsigned pixel, oldest row (window top).
- row1  in  WIDTH: unsigned pixel, middle row.
- row2  in  WIDTH: unsigned pixel, current row (window bottom).
- w_load  in  1: capture w_in into the kernel register.
- w_in  in  9*WIDTH: signed weights; k=3r+c at w_in[k*WIDTH +: WIDTH]; r=0 top, c=2 newest column.
- out_data  out  ACC_W: signed convolution result.
- out_valid  out  1: out_data is valid, one-cycle pulse per window.
- out_last  out  1: qualifies the final window of a frame.

## Operation
- Window: 3x3 registers win[r][c]. On tap_valid, each row shifts c0←c1←c2, and c2 takes the row tap (r0←row0, r1←row1, r2←row2). Without tap_valid the window holds.
- Position: col counts 0..IMG_W-1 on each tap_valid. On wrap, col returns to 0 and row increments, 0..IMG_H-1. row wraps to 0 after the last pixel of the frame. The counters reflect the position of the tap being accepted.
- A window is valid when the accepted tap has col≥2 and row≥2. Valid windows per frame: (IMG_W-2)*(IMG_H-2). A window is last when it is valid with col=IMG_W-1 and row=IMG_H-1.
- Stage 1: nine products p_k = zero-extended pixel (WIDTH+1 signed) × signed weight, each 2*WIDTH+1 bits. Weights are taken from the kernel register as it stands at that edge.
- Stage 2: three row partial sums, 2*WIDTH+3 bits each.
- Stage 3: final sum, sign-extended to ACC_W. Full precision, no overflow possible.
- Valid and last flags travel alongside the data through all stages. The pipeline advances every cycle.
- Kernel: w_load=1 captures w_in at that edge. Products computed at the same edge still use the old kernel.
- sclr: zeroes col, row and all pipeline valid/last flags. Window and data registers are kept. When sclr and tap_valid are both high, sclr wins: the tap is dropped, and neither the window nor the counters advance. sclr does not clear the kernel.
- rst: all registers go to 0, including window, counters, kernel, and out_data/out_valid/out_last. A reset mid-frame discards in-flight results; the next tap is treated as row 0, col 0.

## Timing
- Latency: for a valid window completed by a tap accepted at edge k, out_valid=1 during the cycle after edge k+3. out_data and out_last are aligned with out_valid.
- Throughput: one result per cycle with back-to-back tap_valid.
- Idle cycles on tap_valid create gaps in out_valid and never duplicate results.
- When out_valid=0, out_data holds its last value (don't-care for checking); out_last=0.

## Configuration
- CONV_RELU_EN defined: stage 3 clamps negative sums to 0 (ReLU). out_data is then never negative.
- Not defined: out_data is the raw signed sum.
- Latency is identical in both cases.

## Test plan
- IMG_W=IMG_H=4, all taps=1, all weights=1, continuous tap_valid: exactly 4 results of 9. out_last is on the 4th result only. First out_valid arrives 3 cycles after the 11th tap edge.
- Centre weight −1, others 0, pixels 200, RELU off: results −200. With CONV_RELU_EN: results 0.
- Pixels 255, weights −128: result −293760. Weights 127: result 291465. Neither may wrap.
- tap_valid toggled 1-0-1-0 over the frame: same 4 values as the continuous run, each 3 cycles after its completing tap, no extras.
- rst asserted after 7 taps, then a full frame is fed: no output from the partial frame, then 4 correct results. sclr plus tap_valid on the same cycle: that tap is ignored and counters read 0.
- w_load pulsed on the same edge as a valid window's multiply: that result uses the old kernel; the next result uses the new one.
